// File: rtl/dm_cache_plru.sv
// dm_cache_plru: tree pseudo-LRU victim selection for a 4-way set-associative
// cache. It keeps one 3-bit tree {b2,b1,b0} per set. b0 is the root, b1 picks
// between ways 0/1, and b2 picks between ways 2/3.
// A lookup returns its victim one cycle later.
// Hits and fills update the tree through a one-entry pending stage (P).
// Lookups and back-to-back accesses forward from P.
// Optional build macro: PLRU_INVALID_FIRST_EN. When it is defined, an invalid
// way is chosen before the tree decode.
module dm_cache_plru #(
    parameter int SET_NUM = 128,
    localparam int IW = $clog2(SET_NUM)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          lookup_valid,
    input  logic [IW-1:0] lookup_index,
    input  logic [3:0]    way_valid,
    input  logic          access_valid,
    input  logic [IW-1:0] access_index,
    input  logic [1:0]    access_way,
    output logic          victim_valid,
    output logic [1:0]    victim_way
);

    // Tree decode: the root selects a side, and that side's node selects the way.
    function automatic logic [1:0] tree_victim(input logic [2:0] t);
        if (!t[0]) return t[1] ? 2'd1 : 2'd0;
        else       return t[2] ? 2'd3 : 2'd2;
    endfunction

    // Update: every node on the path to w is pointed away from w.
    function automatic logic [2:0] tree_touch(input logic [2:0] t, input logic [1:0] w);
        logic [2:0] n;
        n = t;
        n[0] = (w < 2'd2);
        if (w < 2'd2) n[1] = (w == 2'd0);
        else          n[2] = (w == 2'd2);
        return n;
    endfunction

    logic [2:0]    tree_q [SET_NUM];
    logic          p_valid_q;
    logic [IW-1:0] p_index_q;
    logic [2:0]    p_tree_q;
    logic [2:0]    p_tree_d;
    logic [2:0]    acc_tree;
    logic [2:0]    look_tree;
    logic [1:0]    victim_d;
    logic          victim_valid_q;
    logic [1:0]    victim_way_q;

    // Effective trees. P holds the newest value for its index until it commits.
    // A same-cycle access never reaches the lookup path.
    always_comb begin
        acc_tree  = tree_q[access_index];
        look_tree = tree_q[lookup_index];
        if (p_valid_q && (p_index_q == access_index)) acc_tree  = p_tree_q;
        if (p_valid_q && (p_index_q == lookup_index)) look_tree = p_tree_q;
        p_tree_d = tree_touch(acc_tree, access_way);
    end

`ifdef PLRU_INVALID_FIRST_EN
    // Victim choice: the lowest invalid way wins; otherwise the tree decides.
    always_comb begin
        victim_d = tree_victim(look_tree);
        if      (!way_valid[0]) victim_d = 2'd0;
        else if (!way_valid[1]) victim_d = 2'd1;
        else if (!way_valid[2]) victim_d = 2'd2;
        else if (!way_valid[3]) victim_d = 2'd3;
    end
`else
    // Victim choice: the tree decode only. way_valid has no effect in this build.
    logic unused_way_valid;
    assign unused_way_valid = ^way_valid;
    always_comb begin
        victim_d = tree_victim(look_tree);
    end
`endif

    // Pending stage and array commit: P captures each access and writes the
    // array on the following edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_valid_q <= 1'b0;
            p_index_q <= '0;
            p_tree_q  <= '0;
            for (int i = 0; i < SET_NUM; i++) tree_q[i] <= 3'b000;
        end else begin
            if (p_valid_q) tree_q[p_index_q] <= p_tree_q;
            p_valid_q <= access_valid;
            if (access_valid) begin
                p_index_q <= access_index;
                p_tree_q  <= p_tree_d;
            end
        end
    end

    // Result register: victim_way holds its value when no lookup is made.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            victim_valid_q <= 1'b0;
            victim_way_q   <= 2'd0;
        end else begin
            victim_valid_q <= lookup_valid;
            if (lookup_valid) victim_way_q <= victim_d;
        end
    end

    assign victim_valid = victim_valid_q;
    assign victim_way   = victim_way_q;

endmodule

// File: tb/tb_dm_cache_plru.sv
// tb_dm_cache_plru: directed checks of dm_cache_plru.
// Expected values are hand-computed tree states.
module tb_dm_cache_plru;

    localparam int SET_NUM = 128;
    localparam int IW = $clog2(SET_NUM);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          lookup_valid = 1'b0;
    logic [IW-1:0] lookup_index = '0;
    logic [3:0]    way_valid = 4'hf;
    logic          access_valid = 1'b0;
    logic [IW-1:0] access_index = '0;
    logic [1:0]    access_way = '0;
    logic          victim_valid;
    logic [1:0]    victim_way;

    int n_tests = 0;
    int n_fail  = 0;

    dm_cache_plru #(.SET_NUM(SET_NUM)) dut (
        .clk(clk), .rst(rst),
        .lookup_valid(lookup_valid), .lookup_index(lookup_index), .way_valid(way_valid),
        .access_valid(access_valid), .access_index(access_index), .access_way(access_way),
        .victim_valid(victim_valid), .victim_way(victim_way)
    );

    // clock
    always #5 clk = ~clk;

    // comparison helper
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance one edge; inputs are driven and outputs sampled 1ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic lv, input int li, input logic [3:0] wv,
                         input logic av, input int ai, input int aw);
        lookup_valid = lv;
        lookup_index = IW'(li);
        way_valid    = wv;
        access_valid = av;
        access_index = IW'(ai);
        access_way   = 2'(aw);
    endtask

    task automatic idle();
        drive(1'b0, 0, 4'hf, 1'b0, 0, 0);
    endtask

    // lookup only; check the result on the next cycle
    task automatic lookup_check(input string tag, input int idx, input logic [3:0] wv, input int exp);
        drive(1'b1, idx, wv, 1'b0, 0, 0);
        tick();
        check({tag, "_vld"}, 32'(victim_valid), 32'd1);
        check({tag, "_way"}, 32'(victim_way), 32'(exp));
    endtask

`ifdef PLRU_INVALID_FIRST_EN
    localparam bit INV_FIRST = 1'b1;
`else
    localparam bit INV_FIRST = 1'b0;
`endif

    initial begin
        // reset
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("rst_vld", 32'(victim_valid), 32'd0);
        check("rst_way", 32'(victim_way), 32'd0);
        rst = 1'b0;
        tick();

        // cleared tree, set 5 -> way 0
        lookup_check("set5_init", 5, 4'hf, 0);
        idle();
        tick();
        check("nolookup_vld", 32'(victim_valid), 32'd0);

        // set 5: way 0 then way 2; lookups at T, T+1, T+2 and T+3
        drive(1'b1, 5, 4'hf, 1'b1, 5, 0);      // T: lookup sees the old tree 000
        tick();
        check("s5_T_way", 32'(victim_way), 32'd0);
        drive(1'b1, 5, 4'hf, 1'b1, 5, 2);      // T+1: lookup sees P = {b1=1,b0=1}
        tick();
        check("s5_T1_way", 32'(victim_way), 32'd2);
        drive(1'b1, 5, 4'hf, 1'b0, 0, 0);      // T+2: P holds the chained tree b2=1,b1=1,b0=0
        tick();
        check("s5_T2_way", 32'(victim_way), 32'd1);
        lookup_check("s5_T3", 5, 4'hf, 1);     // T+3: read from the array

        // hold: victim_way keeps its value with no lookup
        idle();
        tick();
        check("hold_vld", 32'(victim_valid), 32'd0);
        check("hold_way", 32'(victim_way), 32'd1);

        // forwarding: set 9 way 3 -> tree 000 -> victim 0
        drive(1'b0, 0, 4'hf, 1'b1, 9, 3);
        tick();
        lookup_check("s9_fwd", 9, 4'hf, 0);
        // forwarding: set 10 way 0 -> b1=1,b0=1 -> victim 2
        drive(1'b0, 0, 4'hf, 1'b1, 10, 0);
        tick();
        lookup_check("s10_fwd", 10, 4'hf, 2);

        // invalid-first rule
        lookup_check("s3_inv1011", 3, 4'b1011, INV_FIRST ? 2 : 0);
        lookup_check("s3_inv0111", 3, 4'b0111, INV_FIRST ? 3 : 0);
        lookup_check("s10_inv1110", 10, 4'b1110, INV_FIRST ? 0 : 2);
        lookup_check("s10_inv0000", 10, 4'b0000, INV_FIRST ? 0 : 2);

        // set 7 ways 0..3 back to back; set 8 lookups alongside
        for (int w = 0; w < 4; w++) begin
            drive(1'b1, 8, 4'hf, 1'b1, 7, w);
            tick();
            check($sformatf("s8_side_%0d", w), 32'(victim_way), 32'd0);
        end
        lookup_check("s7_final", 7, 4'hf, 0);

        // different indices back to back: set 11 way 1, then set 12 way 0
        drive(1'b0, 0, 4'hf, 1'b1, 11, 1);
        tick();
        drive(1'b0, 0, 4'hf, 1'b1, 12, 0);
        tick();
        idle();
        tick();
        lookup_check("s11_commit", 11, 4'hf, 2);
        lookup_check("s12_commit", 12, 4'hf, 2);

        // reset while P holds set 2; set 2 would otherwise give victim 2
        drive(1'b0, 0, 4'hf, 1'b1, 2, 0);
        tick();
        drive(1'b1, 2, 4'hf, 1'b0, 0, 0);
        rst = 1'b1;
        #1;
        check("mid_rst_vld_async", 32'(victim_valid), 32'd0);
        check("mid_rst_way_async", 32'(victim_way), 32'd0);
        tick();
        check("mid_rst_vld", 32'(victim_valid), 32'd0);
        rst = 1'b0;
        lookup_check("s2_after_rst", 2, 4'hf, 0);
        lookup_check("s10_after_rst", 10, 4'hf, 0);

        idle();
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
